mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, meaning the number of cycles the memory address is held per access (legal range 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port i_req  input  1  instruction-side refill request.
REQ-005 SHALL have port i_addr  input  32  instruction-side byte address.
REQ-006 SHALL have port i_ack  output  1  one-cycle completion pulse to the instruction side.
REQ-007 SHALL have port i_rdata  output  32  instruction-side read data.
REQ-008 SHALL have port d_req  input  1  data-side request.
REQ-009 SHALL have port d_wen  input  1  data-side write enable, qualified by d_req.
REQ-010 SHALL have port d_addr  input  32  data-side byte address.
REQ-011 SHALL have port d_wdata  input  32  data-side write data.
REQ-012 SHALL have port d_ack  output  1  one-cycle completion pulse to the data side.
REQ-013 SHALL have port d_rdata  output  32  data-side read data.
REQ-014 SHALL have port m_addr  output  32  shared memory address.
REQ-015 SHALL have port m_wen  output  1  shared memory write enable.
REQ-016 SHALL have port m_wdata  output  32  shared memory write data.
REQ-017 SHALL have port m_rdata  input  32  shared memory combinational read data.
REQ-018 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 SHALL implement the three-state FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-020 In IDLE with any request: grant one requester; latch its addr, wen and wdata (wen forced 0 for the i side); load the counter with MEM_LATENCY-1; go to ACCESS.
REQ-021 In ACCESS: drive the latched addr/wdata on m_addr/m_wdata; decrement the counter each cycle; at counter==0, capture m_rdata into the granted side's rdata register and go to DONE.
REQ-022 m_wen SHALL be high only in the final ACCESS cycle of a granted write, giving exactly one write pulse per write.
REQ-023 In DONE: assert the granted side's ack for exactly one cycle, then return to IDLE.
REQ-024 ack SHALL rise MEM_LATENCY+1 cycles after the edge at which the request is sampled in IDLE.
REQ-025 A write SHALL leave d_rdata unchanged; i_rdata/d_rdata SHALL hold until that side's next completed read.
REQ-026 In IDLE and DONE, m_addr, m_wdata SHALL be 0 and m_wen SHALL be 0.
REQ-027 Requester contract: req held stable until ack and low in the cycle after ack unless a new request; a req high in IDLE is always a new request.
REQ-028 A request arriving while busy SHALL wait, never be dropped, and be considered at the next IDLE.
REQ-029 The two ack outputs SHALL never be high in the same cycle.

Reset
REQ-030 reset low at a rising edge SHALL force IDLE, counter 0, all acks 0, i_rdata/d_rdata 0, m_* 0, busy 0, and last-served = i side.
REQ-031 Reset mid-ACCESS or mid-DONE SHALL abort with no ack and no m_wen pulse from the next cycle on.

Configuration
REQ-032 With ARB_RR_EN defined: on simultaneous requests, grant the side not last served; last-served updates at each grant.
REQ-033 Without ARB_RR_EN: on simultaneous requests, the d side always wins and no last-served state is implemented.

Verification
REQ-034 MEM_LATENCY=2; i_req, i_addr=0x10, m_rdata=0x2010_0005 -> i_ack exactly 3 cycles after sampling, i_rdata=0x2010_0005, m_wen never high.
REQ-035 d_req+d_wen, d_addr=0x54, d_wdata=0x7 -> one m_wen pulse with m_addr=0x54 and m_wdata=0x7, d_ack next cycle, d_rdata unchanged.
REQ-036 i_req and d_req held continuously -> with ARB_RR_EN the grant order is d, i, d, i; without it the d side is granted every time while d_req stays high.
REQ-037 d_req rises during an i access -> d served immediately after i_ack; busy low for exactly one cycle between the two accesses.
REQ-038 reset low in the second ACCESS cycle -> no ack, no m_wen, busy 0 on the next cycle; a fresh request then completes normally.
REQ-039 MEM_LATENCY=1 -> ack 2 cycles after sampling; MEM_LATENCY=16 -> ack 17 cycles after sampling.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction / data) arbiter in front of a single
// memory port with a fixed access latency.
//
// Optional feature: define ARB_RR_EN to alternate grants between the two sides
// on simultaneous requests. Without it the data side always wins a tie.
//
// Parameter MEM_LATENCY (1..16) is the number of cycles the memory address is
// held per access. The granted side's ack appears in the cycle after the last
// access cycle, i.e. MEM_LATENCY+1 cycles after the request is taken in IDLE.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transaction; requests are sampled and one side is granted
// ACCESS | latched address/data driven to memory, counter runs down to 0
// DONE   | one-cycle ack to the granted side, then back to IDLE
module mem_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] m_addr,
    output logic        m_wen,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 16) begin : g_bad_latency
        $error("mem_arbiter: MEM_LATENCY must be in 1..16");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              grant_d;       // 1: current transaction belongs to the d side
    logic              grant_d_nxt;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_addr_nxt;
    logic [31:0]       lat_wdata;
    logic [31:0]       lat_wdata_nxt;
    logic              lat_wen;
    logic              lat_wen_nxt;
    logic [31:0]       i_rdata_nxt;
    logic [31:0]       d_rdata_nxt;
    logic              any_req;
    logic              pick_d;        // tie-break result, valid when any_req
    logic              last_access;

    assign any_req     = i_req | d_req;
    assign last_access = (state == ST_ACCESS) && (cnt == '0);

`ifdef ARB_RR_EN
    logic last_d;                     // 1: d side was granted most recently
    logic last_d_nxt;

    // On a tie, grant whichever side did not win the previous grant.
    always_comb begin
        pick_d = d_req && (!i_req || !last_d);
    end

    // Last-served marker moves with every grant; reset points it at the i side.
    always_comb begin
        last_d_nxt = last_d;
        if (state == ST_IDLE && any_req) begin
            last_d_nxt = pick_d;
        end
    end

    // Last-served register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_d <= 1'b0;
        end else begin
            last_d <= last_d_nxt;
        end
    end
`else
    // Fixed priority: the data side wins any tie.
    always_comb begin
        pick_d = d_req;
    end
`endif

    // Next-state, transaction latch and read-data capture.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        grant_d_nxt   = grant_d;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        lat_wen_nxt   = lat_wen;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;

        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d_nxt = pick_d;
                    cnt_nxt     = CNT_LOAD;
                    state_nxt   = ST_ACCESS;
                    if (pick_d) begin
                        lat_addr_nxt  = d_addr;
                        lat_wdata_nxt = d_wdata;
                        lat_wen_nxt   = d_wen;
                    end else begin
                        // Instruction refills are always reads.
                        lat_addr_nxt  = i_addr;
                        lat_wdata_nxt = '0;
                        lat_wen_nxt   = 1'b0;
                    end
                end
            end

            ST_ACCESS: begin
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                    // Writes leave both read-data registers untouched.
                    if (!lat_wen) begin
                        if (grant_d) begin
                            d_rdata_nxt = m_rdata;
                        end else begin
                            i_rdata_nxt = m_rdata;
                        end
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            grant_d   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wen   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            grant_d   <= grant_d_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
            lat_wen   <= lat_wen_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
        end
    end

    // Memory port is only driven during ACCESS; the write strobe is confined to
    // the final access cycle so each write produces exactly one pulse.
    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_wen   = 1'b0;
        if (state == ST_ACCESS) begin
            m_addr  = lat_addr;
            m_wdata = lat_wdata;
            m_wen   = lat_wen && last_access;
        end
    end

    // Acks decode straight from DONE and the owner bit, so they are mutually
    // exclusive and vanish the cycle after a reset.
    always_comb begin
        i_ack = (state == ST_DONE) && !grant_d;
        d_ack = (state == ST_DONE) &&  grant_d;
        busy  = (state != ST_IDLE);
    end

endmodule
